// File: rtl/pong_display_pkg.sv
// Shared definitions for the pong overlay renderers: game-state encoding,
// winner codes and default tick-bar geometry.
package pong_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [9:0] BAR_TOP   = 10'd20;
    localparam logic [9:0] BAR_BOT   = 10'd25;
    localparam logic [9:0] BAR_W     = 10'd5;
    localparam logic [9:0] BAR_SPACE = 10'd5;

    localparam bit DIR_RIGHT = 1'b0;
    localparam bit DIR_LEFT  = 1'b1;

    // A player running out means the other one wins; both out is a draw.
    function automatic logic [1:0] winner_code(input logic p0_out, input logic p1_out);
        return {p0_out, p1_out};
    endfunction

endpackage

// File: rtl/score_bar_tracker_if.sv
// Game-logic / display-controller side signals of the score bar tracker.
interface score_bar_tracker_if #(
    parameter int LIVES_W = 4
);
    logic               frame_tick;
    logic               new_game;
    logic [1:0]         miss;
    logic [9:0]         xpix;
    logic [9:0]         ypix;
    logic [LIVES_W-1:0] lives0;
    logic [LIVES_W-1:0] lives1;
    logic               game_over;
    logic [1:0]         winner;
    logic               pixval;
    logic               altcolor;

    modport master (
        output frame_tick, new_game, miss, xpix, ypix,
        input  lives0, lives1, game_over, winner, pixval, altcolor
    );

    modport slave (
        input  frame_tick, new_game, miss, xpix, ypix,
        output lives0, lives1, game_over, winner, pixval, altcolor
    );
endinterface

// File: rtl/score_lane.sv
// One player's lives counter, lost-bar blink timer and bar hit test.
// DIRECTION selects whether bars grow rightward from START or leftward from it.
module score_lane
    import pong_display_pkg::*;
#(
    parameter int         MAX_LIVES    = 7,
    parameter int         LIVES_W      = 4,
    parameter logic [9:0] START        = 10'd50,
    parameter bit         DIRECTION    = DIR_RIGHT,
    parameter logic [9:0] TOP          = BAR_TOP,
    parameter logic [9:0] BOT          = BAR_BOT,
    parameter logic [9:0] W            = BAR_W,
    parameter logic [9:0] SPACE        = BAR_SPACE,
    parameter int         BLINK_FRAMES = 32,
    parameter int         BLINK_HALF   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reload_i,
    input  logic               miss_i,
    input  logic               frame_tick_i,
    input  logic [9:0]         xpix_i,
    input  logic [9:0]         ypix_i,
    output logic [LIVES_W-1:0] lives_o,
    output logic               lit_o,
    output logic               blink_o
);

    localparam int                  BLINK_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [BLINK_W-1:0]  HALF_V  = BLINK_W'(BLINK_HALF);
    localparam logic [9:0]          PITCH   = W + SPACE;

    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LIVES_W-1:0] blink_idx_q, blink_idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [BLINK_W-1:0] blink_quot;
    logic               blink_on;

    always_comb begin
        lives_d     = lives_q;
        blink_idx_d = blink_idx_q;
        blink_cnt_d = blink_cnt_q;
        if (reload_i) begin
            lives_d     = LIVES_W'(MAX_LIVES);
            blink_idx_d = '0;
            blink_cnt_d = '0;
        end else if (miss_i && lives_q != '0) begin
            lives_d     = lives_q - LIVES_W'(1);
            blink_idx_d = lives_q - LIVES_W'(1);
            blink_cnt_d = BLINK_W'(BLINK_FRAMES);
        end else if (frame_tick_i && blink_cnt_q != '0) begin
            blink_cnt_d = blink_cnt_q - BLINK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lives_q     <= LIVES_W'(MAX_LIVES);
            blink_idx_q <= '0;
            blink_cnt_q <= '0;
        end else begin
            lives_q     <= lives_d;
            blink_idx_q <= blink_idx_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign blink_quot = blink_cnt_q / HALF_V;
    assign blink_on   = (blink_cnt_q != '0) && blink_quot[0];

    // Bars never overlap, so at most one index can match the pixel.
    always_comb begin
        logic [9:0] lo;
        logic [9:0] hi;
        logic       in_y;
        lit_o   = 1'b0;
        blink_o = 1'b0;
        in_y    = (ypix_i > TOP) && (ypix_i <= BOT);
        for (int i = 0; i < MAX_LIVES; i++) begin
            if (DIRECTION == DIR_RIGHT) begin
                lo = START + 10'(i) * PITCH;
                hi = lo + W;
            end else begin
                hi = START - 10'(i) * PITCH;
                lo = hi - W;
            end
            if (in_y && xpix_i >= lo && xpix_i < hi) begin
                if (LIVES_W'(i) < lives_q) lit_o = 1'b1;
                if (blink_on && LIVES_W'(i) == blink_idx_q) blink_o = 1'b1;
            end
        end
    end

    assign lives_o = lives_q;

endmodule

// File: rtl/score_bar_tracker.sv
// Tracks both players' lives from miss events, detects game over / winner and
// renders the two tick-bar gauges into the pixel stream with a registered output.
module score_bar_tracker
    import pong_display_pkg::*;
#(
    parameter int         MAX_LIVES    = 7,
    parameter int         LIVES_W      = 4,
    parameter logic [9:0] LEFT_START   = 10'd50,
    parameter logic [9:0] RIGHT_START  = 10'd590,
    parameter logic [9:0] TOP          = BAR_TOP,
    parameter logic [9:0] BOT          = BAR_BOT,
    parameter logic [9:0] W            = BAR_W,
    parameter logic [9:0] SPACE        = BAR_SPACE,
    parameter int         BLINK_FRAMES = 32,
    parameter int         BLINK_HALF   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    score_bar_tracker_if.slave bus
);

    game_state_e        state_q, state_d;
    logic [1:0]         winner_q, winner_d;
    logic               pixval_q, altcolor_q;
    logic [1:0]         miss_ok;
    logic [LIVES_W-1:0] lives0, lives1;
    logic               lit0, lit1, blink0, blink1;
    logic               out0, out1;
    logic               over_alt;

    // new_game wins over a simultaneous miss, and misses only count while playing.
    assign miss_ok = (state_q == ST_PLAY && !bus.new_game) ? bus.miss : 2'b00;

    score_lane #(
        .MAX_LIVES(MAX_LIVES), .LIVES_W(LIVES_W), .START(LEFT_START), .DIRECTION(DIR_RIGHT),
        .TOP(TOP), .BOT(BOT), .W(W), .SPACE(SPACE),
        .BLINK_FRAMES(BLINK_FRAMES), .BLINK_HALF(BLINK_HALF)
    ) u_lane0 (
        .clk(clk), .rst_n(rst_n), .reload_i(bus.new_game), .miss_i(miss_ok[0]),
        .frame_tick_i(bus.frame_tick), .xpix_i(bus.xpix), .ypix_i(bus.ypix),
        .lives_o(lives0), .lit_o(lit0), .blink_o(blink0)
    );

    score_lane #(
        .MAX_LIVES(MAX_LIVES), .LIVES_W(LIVES_W), .START(RIGHT_START), .DIRECTION(DIR_LEFT),
        .TOP(TOP), .BOT(BOT), .W(W), .SPACE(SPACE),
        .BLINK_FRAMES(BLINK_FRAMES), .BLINK_HALF(BLINK_HALF)
    ) u_lane1 (
        .clk(clk), .rst_n(rst_n), .reload_i(bus.new_game), .miss_i(miss_ok[1]),
        .frame_tick_i(bus.frame_tick), .xpix_i(bus.xpix), .ypix_i(bus.ypix),
        .lives_o(lives1), .lit_o(lit1), .blink_o(blink1)
    );

    assign out0 = miss_ok[0] && (lives0 == LIVES_W'(1));
    assign out1 = miss_ok[1] && (lives1 == LIVES_W'(1));

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        if (bus.new_game) begin
            state_d  = ST_PLAY;
            winner_d = WIN_NONE;
        end else if (state_q == ST_PLAY && (out0 || out1)) begin
            state_d  = ST_OVER;
            winner_d = winner_code(out0, out1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            winner_q <= WIN_NONE;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
        end
    end

    assign over_alt = (state_q == ST_OVER) &&
                      ((winner_q[0] && lit0) || (winner_q[1] && lit1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixval_q   <= 1'b0;
            altcolor_q <= 1'b0;
        end else begin
            pixval_q   <= lit0 | blink0 | lit1 | blink1;
            altcolor_q <= blink0 | blink1 | over_alt;
        end
    end

    assign bus.lives0    = lives0;
    assign bus.lives1    = lives1;
    assign bus.game_over = (state_q == ST_OVER);
    assign bus.winner    = winner_q;
    assign bus.pixval    = pixval_q;
    assign bus.altcolor  = altcolor_q;

endmodule

// File: tb/tb_score_bar_tracker.sv
// Scoreboard bench for score_bar_tracker: directed stimulus pushes expected
// results, a negedge monitor pops and compares them against the outputs.
module tb_score_bar_tracker;

    typedef struct {
        int         due;
        bit         isState;
        string      name;
        logic [3:0] l0;
        logic [3:0] l1;
        logic       go;
        logic [1:0] w;
        logic       pix;
        logic       alt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cycle = 0;
    int   testsRun = 0;
    int   failCount = 0;
    bit   drainReq = 1'b0;
    int   drainDeadline = 0;
    exp_t expQ[$];
    exp_t monItem;

    score_bar_tracker_if #(.LIVES_W(4)) bus();

    score_bar_tracker dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: every due expectation is compared while outputs are stable.
    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].due <= cycle) begin
            monItem = expQ.pop_front();
            testsRun++;
            if (monItem.isState) begin
                if (bus.lives0 !== monItem.l0 || bus.lives1 !== monItem.l1 ||
                    bus.game_over !== monItem.go || bus.winner !== monItem.w) begin
                    failCount++;
                    $display("[TB] FAIL %s: got lives0=%0d lives1=%0d game_over=%b winner=%b, expected lives0=%0d lives1=%0d game_over=%b winner=%b",
                             monItem.name, bus.lives0, bus.lives1, bus.game_over, bus.winner,
                             monItem.l0, monItem.l1, monItem.go, monItem.w);
                end
            end else begin
                if (bus.pixval !== monItem.pix || bus.altcolor !== monItem.alt) begin
                    failCount++;
                    $display("[TB] FAIL %s: got pixval=%b altcolor=%b, expected pixval=%b altcolor=%b",
                             monItem.name, bus.pixval, bus.altcolor, monItem.pix, monItem.alt);
                end
            end
        end
        if (drainReq && cycle > drainDeadline && expQ.size() > 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size());
            expQ.delete();
        end
    end

    task automatic applyStimulus(input logic ng, input logic [1:0] m, input logic ft,
                                 input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        bus.new_game   = ng;
        bus.miss       = m;
        bus.frame_tick = ft;
        bus.xpix       = x;
        bus.ypix       = y;
    endtask

    task automatic checkOutput(input string name, input bit isState, input int lag,
                               input logic [3:0] l0, input logic [3:0] l1, input logic go,
                               input logic [1:0] w, input logic pix, input logic alt);
        exp_t e;
        e.due = cycle + lag;
        e.isState = isState;
        e.name = name;
        e.l0 = l0;
        e.l1 = l1;
        e.go = go;
        e.w = w;
        e.pix = pix;
        e.alt = alt;
        expQ.push_back(e);
    endtask

    task automatic checkState(input string name, input logic [3:0] l0, input logic [3:0] l1,
                              input logic go, input logic [1:0] w);
        checkOutput(name, 1'b1, 1, l0, l1, go, w, 1'b0, 1'b0);
    endtask

    task automatic checkPix(input string name, input logic pix, input logic alt);
        checkOutput(name, 1'b0, 1, 4'd0, 4'd0, 1'b0, 2'b00, pix, alt);
    endtask

    logic [9:0] geoX[12] = '{10'd50, 10'd51, 10'd52, 10'd54, 10'd55, 10'd49,
                             10'd589, 10'd589, 10'd585, 10'd584, 10'd110, 10'd525};
    logic [9:0] geoY[12] = '{10'd21, 10'd21, 10'd21, 10'd21, 10'd21, 10'd21,
                             10'd25, 10'd20, 10'd22, 10'd22, 10'd21, 10'd26};
    logic       geoP[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int  c;
        logic on;
        rst_n          = 1'b0;
        bus.new_game   = 1'b0;
        bus.miss       = 2'b00;
        bus.frame_tick = 1'b0;
        bus.xpix       = 10'd0;
        bus.ypix       = 10'd0;
        checkOutput("reset_state", 1'b1, 0, 4'd7, 4'd7, 1'b0, 2'b00, 1'b0, 1'b0);
        checkOutput("reset_pix", 1'b0, 0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 2'b00, 1'b0, 10'd0, 10'd0);
        checkState("new_game", 4'd7, 4'd7, 1'b0, 2'b00);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 2'b00, 1'b0, geoX[i], geoY[i]);
            checkPix($sformatf("geom%0d_x%0d_y%0d", i, geoX[i], geoY[i]), geoP[i], 1'b0);
        end

        // Player 0 loses bar 6 (x 110..114) and it blinks.
        applyStimulus(1'b0, 2'b01, 1'b0, 10'd110, 10'd21);
        checkState("miss_p0", 4'd6, 4'd7, 1'b0, 2'b00);
        checkPix("miss_p0_pix_same_cycle", 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 10'd110, 10'd21);
        checkPix("blink_cnt32", 1'b0, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(1'b0, 2'b00, 1'b1, 10'd0, 10'd0);
            applyStimulus(1'b0, 2'b00, 1'b0, 10'd110, 10'd21);
            c  = 32 - k;
            on = (c != 0) && (((c / 4) % 2) == 1);
            checkPix($sformatf("blink_cnt%0d", c), on, on);
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 10'd100, 10'd21);
        checkPix("steady_bar5", 1'b1, 1'b0);

        // Player 1 runs out of lives.
        for (int n = 1; n <= 7; n++) begin
            applyStimulus(1'b0, 2'b10, 1'b0, 10'd0, 10'd0);
            checkState($sformatf("miss_p1_%0d", n), 4'd6, 4'(7 - n), (n == 7),
                       (n == 7) ? 2'b01 : 2'b00);
        end
        applyStimulus(1'b0, 2'b11, 1'b0, 10'd50, 10'd21);
        checkState("over_ignore_miss11", 4'd6, 4'd0, 1'b1, 2'b01);
        checkPix("over_winner_bar0", 1'b1, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b0, 10'd589, 10'd25);
        checkState("over_ignore_miss01", 4'd6, 4'd0, 1'b1, 2'b01);
        checkPix("over_loser_bar0", 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 10'd110, 10'd21);
        checkPix("over_p0_bar6_dark", 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 10'd100, 10'd21);
        checkPix("over_winner_bar5", 1'b1, 1'b1);

        // Draw: both players lose their last life together.
        applyStimulus(1'b1, 2'b00, 1'b0, 10'd0, 10'd0);
        checkState("draw_new_game", 4'd7, 4'd7, 1'b0, 2'b00);
        for (int n = 1; n <= 6; n++) begin
            applyStimulus(1'b0, 2'b11, 1'b0, 10'd0, 10'd0);
            checkState($sformatf("draw_miss_%0d", n), 4'(7 - n), 4'(7 - n), 1'b0, 2'b00);
        end
        applyStimulus(1'b0, 2'b11, 1'b0, 10'd50, 10'd21);
        checkState("draw_over", 4'd0, 4'd0, 1'b1, 2'b11);
        checkPix("draw_last_bar_before", 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 10'd50, 10'd21);
        checkPix("draw_bar0_dark", 1'b0, 1'b0);

        // new_game beats a simultaneous miss: no decrement, no blink.
        applyStimulus(1'b1, 2'b01, 1'b0, 10'd0, 10'd0);
        checkState("ng_beats_miss", 4'd7, 4'd7, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b00, 1'b1, 10'd0, 10'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 10'd110, 10'd21);
        checkPix("ng_beats_miss_no_blink", 1'b1, 1'b0);

        // Asynchronous reset in the middle of an "on" blink phase.
        applyStimulus(1'b0, 2'b01, 1'b0, 10'd0, 10'd0);
        checkState("pre_reset_miss", 4'd6, 4'd7, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b00, 1'b1, 10'd110, 10'd21);
        applyStimulus(1'b0, 2'b00, 1'b0, 10'd110, 10'd21);
        checkPix("pre_reset_blink_on", 1'b1, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b0, 10'd110, 10'd21);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        checkOutput("async_reset_state", 1'b1, 0, 4'd7, 4'd7, 1'b0, 2'b00, 1'b0, 1'b0);
        checkOutput("async_reset_pix", 1'b0, 0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'b01, 1'b0, 10'd0, 10'd0);
        checkState("idle_ignores_miss", 4'd7, 4'd7, 1'b0, 2'b00);
        applyStimulus(1'b1, 2'b00, 1'b0, 10'd0, 10'd0);
        checkState("resume_new_game", 4'd7, 4'd7, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b01, 1'b0, 10'd0, 10'd0);
        checkState("resume_miss", 4'd6, 4'd7, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b00, 1'b0, 10'd0, 10'd0);

        drainDeadline = cycle + 20;
        drainReq = 1'b1;
        while (expQ.size() != 0) @(negedge clk);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
